// File: rtl/rv_ifu.sv
// Instruction fetch: sequential PC generation, imem requests, 2-entry prefetch buffer; word visible 2 cycles after grant.
// Stall freezes the head and issue stops once credits are used; redirect flushes the buffer and discards in-flight returns.
module rv_ifu #(
    parameter int unsigned     XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            stall_i,
    output logic            inst_valid_o,
    output logic [31:0]     inst_o,
    output logic [XLEN-1:0] pc_o,
    output logic [6:0]      opcode_o
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(2 * DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]  out_pc_q, out_pc_d;
    logic [CNT_W-1:0] outst_q, outst_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [31:0]      mem_q [DEPTH];

    logic             grant, pop, push, discard, live_rsp;
    logic [XLEN-1:0]  redir_pc;
    logic [SUM_W-1:0] live_sum, live_cap, total_sum;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign redir_pc     = redirect_pc_i & ~XLEN'(3);
    assign inst_valid_o = (count_q != '0);
    assign inst_o       = inst_valid_o ? mem_q[head_q] : 32'h0;
    assign opcode_o     = inst_o[6:0];
    assign pc_o         = out_pc_q;
    assign imem_addr_o  = fetch_pc_q;

    assign pop      = inst_valid_o & ~stall_i & ~redirect_i;
    assign discard  = imem_rvalid_i & (drop_q != '0);
    assign live_rsp = imem_rvalid_i & ~discard;
    assign push     = live_rsp & ~redirect_i;

    // A slot freed by this cycle's pop counts as a credit, which is what
    // sustains one instruction per cycle with only two entries.
    assign live_sum  = SUM_W'(outst_q) + SUM_W'(count_q);
    assign live_cap  = SUM_W'(DEPTH) + SUM_W'(pop);
    // Discarded requests no longer hold credits, so cap the total in flight
    // to keep the drop counter bounded under back-to-back redirects.
    assign total_sum = SUM_W'(outst_q) + SUM_W'(drop_q);

    assign imem_req_o = ~rst & ~redirect_i & (live_sum < live_cap)
                      & (total_sum < SUM_W'(2 * DEPTH));
    assign grant      = imem_req_o & imem_gnt_i;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        out_pc_d   = out_pc_q;
        outst_d    = outst_q;
        drop_d     = drop_q;
        count_d    = count_q;
        head_d     = head_q;
        tail_d     = tail_q;
        if (redirect_i) begin
            fetch_pc_d = redir_pc;
            out_pc_d   = redir_pc;
            outst_d    = '0;
            drop_d     = drop_q + outst_q - CNT_W'(imem_rvalid_i);
            count_d    = '0;
            head_d     = '0;
            tail_d     = '0;
        end else begin
            if (grant) fetch_pc_d = fetch_pc_q + XLEN'(4);
            if (pop) begin
                out_pc_d = out_pc_q + XLEN'(4);
                head_d   = ptr_inc(head_q);
            end
            if (push)    tail_d = ptr_inc(tail_q);
            if (discard) drop_d = drop_q - CNT_W'(1);
            outst_d = outst_q + CNT_W'(grant) - CNT_W'(live_rsp);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            out_pc_q   <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
            count_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            out_pc_q   <= out_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[tail_q] <= imem_rdata_i;
    end

    a_no_push_full: assert property (@(posedge clk) disable iff (rst)
        push |-> (count_q < CNT_W'(DEPTH)));

endmodule

// File: tb/tb_rv_ifu.sv
// Scoreboard bench for rv_ifu: expected PCs are queued by the stimulus, a negedge monitor checks every delivered instruction.
module tb_rv_ifu;
    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_o;
    logic [63:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [63:0] redirect_pc_i;
    logic        stall_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [63:0] pc_o;
    logic [6:0]  opcode_o;

    rv_ifu #(.XLEN(64), .RESET_PC(64'h0), .DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i), .stall_i(stall_i),
        .inst_valid_o(inst_valid_o), .inst_o(inst_o), .pc_o(pc_o), .opcode_o(opcode_o)
    );

    always #5 clk = ~clk;

    typedef enum int {C_REQ, C_ADDR, C_VALID, C_INST, C_OPC, C_PC, C_OK} sel_t;
    typedef struct { string name; sel_t sel; logic [63:0] exp; logic [63:0] got; } chk_t;
    typedef struct { logic [63:0] addr; int due; } req_t;

    chk_t        dq[$];
    logic [63:0] exp_q[$];
    req_t        pend[$];
    int          nvec = 0;
    int          nerr = 0;
    int          ndeliv = 0;
    int          cyc = 0;
    int          lat = 1;
    bit          rand_gnt = 1'b0;

    function automatic logic [31:0] word(input logic [63:0] a);
        return a[31:0] * 32'h9E37_79B1 + 32'h0000_0013;
    endfunction

    // memory model: in-order responses, fixed latency after grant, reset with the DUT
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        imem_gnt_i = 1'b1; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                pend.delete();
                imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
            end else if (pend.size() != 0 && pend[0].due <= cyc) begin
                imem_rvalid_i = 1'b1; imem_rdata_i = word(pend[0].addr);
                void'(pend.pop_front());
            end else begin
                imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
            end
            imem_gnt_i = rand_gnt ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    always @(negedge clk) begin
        req_t r;
        if (!rst && imem_req_o && imem_gnt_i) begin
            r.addr = imem_addr_o; r.due = cyc + lat;
            pend.push_back(r);
        end
    end

    // monitor: directed checks posted this cycle, then the delivery scoreboard
    always @(negedge clk) begin
        chk_t        c;
        logic [63:0] got, e;
        logic [31:0] w;
        while (dq.size() != 0) begin
            c = dq.pop_front();
            case (c.sel)
                C_REQ:   got = 64'(imem_req_o);
                C_ADDR:  got = imem_addr_o;
                C_VALID: got = 64'(inst_valid_o);
                C_INST:  got = 64'(inst_o);
                C_OPC:   got = 64'(opcode_o);
                C_PC:    got = pc_o;
                default: got = c.got;
            endcase
            nvec++;
            if (got !== c.exp) begin
                nerr++;
                $display("FAIL %s: got %h, want %h", c.name, got, c.exp);
            end
        end
        if (!rst) begin
            if (inst_valid_o && !stall_i && !redirect_i) begin
                nvec++;
                if (exp_q.size() == 0) begin
                    nerr++;
                    $display("FAIL deliver: got pc %h, want no delivery", pc_o);
                end else begin
                    e = exp_q.pop_front();
                    w = word(e);
                    ndeliv++;
                    if (pc_o !== e || inst_o !== w || opcode_o !== w[6:0]) begin
                        nerr++;
                        $display("FAIL deliver: got pc %h inst %h opc %h, want pc %h inst %h opc %h",
                                 pc_o, inst_o, opcode_o, e, w, w[6:0]);
                    end
                end
            end
            if (!inst_valid_o) begin
                nvec++;
                if (inst_o !== 32'h0 || opcode_o !== 7'h0) begin
                    nerr++;
                    $display("FAIL idle_out: got inst %h opc %h, want 0 0", inst_o, opcode_o);
                end
            end
        end
    end

    task automatic post(input string name, input sel_t s, input logic [63:0] v);
        chk_t c;
        c.name = name; c.sel = s; c.exp = v; c.got = 64'h0;
        dq.push_back(c);
    endtask

    task automatic post_ok(input string name, input bit ok);
        chk_t c;
        c.name = name; c.sel = C_OK; c.exp = 64'd1; c.got = 64'(ok);
        dq.push_back(c);
    endtask

    task automatic step();
        @(posedge clk); #2;
    endtask

    task automatic stream_from(input logic [63:0] pc, input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(pc + 64'(4 * i));
    endtask

    task automatic post_reset(input string tag);
        post({tag, "_req"},   C_REQ,   64'h0);
        post({tag, "_addr"},  C_ADDR,  64'h0);
        post({tag, "_valid"}, C_VALID, 64'h0);
        post({tag, "_inst"},  C_INST,  64'h0);
        post({tag, "_opc"},   C_OPC,   64'h0);
        post({tag, "_pc"},    C_PC,    64'h0);
    endtask

    task automatic wait_deliv(input string name, input int n, input int budget);
        int base = ndeliv;
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (ndeliv - base >= n) begin ok = 1'b1; break; end
        end
        post_ok(name, ok);
    endtask

    task automatic redirect_to(input logic [63:0] target, input logic [63:0] aligned);
        redirect_i = 1'b1; redirect_pc_i = target;
        stream_from(aligned, 200);
        post("redir_req", C_REQ, 64'h0);
        step();
        redirect_i = 1'b0;
        post("redir_valid", C_VALID, 64'h0);
    endtask

    initial begin
        watchdog();
    end

    task automatic watchdog();
        #500000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1);
    endtask

    initial begin
        bit ok;
        rst = 1'b1; redirect_i = 1'b0; redirect_pc_i = 64'h0; stall_i = 1'b0;
        stream_from(64'h0, 200);
        repeat (3) step();
        post_reset("rst");

        // reset release and first-fetch latency
        step(); rst = 1'b0;
        post("c0_req", C_REQ, 64'h1); post("c0_addr", C_ADDR, 64'h0); post("c0_valid", C_VALID, 64'h0);
        step();
        post("c1_req", C_REQ, 64'h1); post("c1_addr", C_ADDR, 64'h4); post("c1_valid", C_VALID, 64'h0);
        step();
        post("c2_valid", C_VALID, 64'h1); post("c2_pc", C_PC, 64'h0);
        for (int i = 0; i < 18; i++) begin
            step();
            post("stream_nobubble", C_VALID, 64'h1);
        end

        // stall: head frozen, no issue while both credits are held
        step(); stall_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            post("stall_valid", C_VALID, 64'h1);
            post("stall_pc", C_PC, exp_q[0]);
            post("stall_inst", C_INST, 64'(word(exp_q[0])));
            post("stall_req", C_REQ, 64'h0);
            step();
        end
        stall_i = 1'b0;
        wait_deliv("post_stall", 8, 20);

        // redirect with two requests in flight
        lat = 3;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (pend.size() == 2 && !imem_rvalid_i) begin ok = 1'b1; break; end
        end
        post_ok("find_outst2", ok);
        redirect_to(64'h101, 64'h100);
        post("redir_tgt_req", C_REQ, 64'h1); post("redir_tgt_addr", C_ADDR, 64'h100);
        wait_deliv("redir_100", 4, 60);

        // redirect in the same cycle as a response
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (imem_rvalid_i) begin ok = 1'b1; break; end
        end
        post_ok("find_rvalid", ok);
        redirect_to(64'h200, 64'h200);
        wait_deliv("redir_200", 2, 60);

        // redirect together with stall
        stall_i = 1'b1;
        redirect_i = 1'b1; redirect_pc_i = 64'h300;
        stream_from(64'h300, 200);
        step();
        redirect_i = 1'b0; stall_i = 1'b0;
        post("redir_stall_valid", C_VALID, 64'h0);
        wait_deliv("redir_300", 3, 60);

        // slow memory with withheld grants
        rand_gnt = 1'b1;
        step();
        redirect_to(64'h400, 64'h400);
        wait_deliv("slow_mem", 20, 600);

        // PC wrap at the top of the address space
        rand_gnt = 1'b0; lat = 1;
        step();
        redirect_i = 1'b1; redirect_pc_i = 64'hFFFF_FFFF_FFFF_FFF8;
        exp_q.delete();
        exp_q.push_back(64'hFFFF_FFFF_FFFF_FFF8);
        exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFC);
        exp_q.push_back(64'h0);
        for (int i = 1; i < 40; i++) exp_q.push_back(64'(4 * i));
        step();
        redirect_i = 1'b0;
        post("wrap_addr", C_ADDR, 64'hFFFF_FFFF_FFFF_FFF8);
        wait_deliv("wrap", 6, 60);

        // asynchronous reset mid-stream, then restart from RESET_PC
        step(); #1;
        rst = 1'b1;
        stream_from(64'h0, 200);
        post_reset("arst");
        repeat (2) step();
        rst = 1'b0;
        post("rst2_req", C_REQ, 64'h1); post("rst2_addr", C_ADDR, 64'h0); post("rst2_valid", C_VALID, 64'h0);
        wait_deliv("restart", 5, 40);

        repeat (2) step();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
